// File: rtl/mmc1_pkg.sv
// Shared constants and types for the MMC1 serial-load front end.
package mmc1_pkg;

   localparam logic [1:0] REG_CONTROL     = 2'b00;
   localparam logic [1:0] REG_CHR0        = 2'b01;
   localparam logic [1:0] REG_CHR1        = 2'b10;
   localparam logic [1:0] REG_PRG         = 2'b11;
   localparam int         SHIFT_LEN       = 5;
   localparam logic [4:0] CTRL_RESET_MASK = 5'b01100;

   typedef enum logic [0:0] {
      CYC_IDLE = 1'b0,
      CYC_HIGH = 1'b1
   } cyc_state_e;

   // Bus fields latched during the M2-high phase of a CPU cycle.
   typedef struct packed {
      logic       romsel_n;
      logic       rw_n;
      logic [1:0] sel;
      logic       d0;
      logic       d7;
   } bus_cap_t;

endpackage

// File: rtl/mmc1_sync.sv
// Multi-stage vector synchronizer for asynchronous CPU bus pins.
module mmc1_sync #(
   parameter int WIDTH  = 7,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] chain_q [STAGES];

   // Plain flop chain; left unreset so it keeps tracking the pins through RST.
   always_ff @(posedge clk_i) begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
         chain_q[i] <= chain_q[i-1];
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 front end: qualifies CPU ROM writes from the synced bus and runs the
// 5-write serial load, emitting register-write and control-reset strobes.
module mmc1_serial_loader
   import mmc1_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int M2_MIN_HIGH = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CPU_M2,
   input  logic       nCPU_ROMSEL,
   input  logic       nCPU_RW,
   input  logic       CPU_A14,
   input  logic       CPU_A13,
   input  logic       CPU_D0,
   input  logic       CPU_D7,
   output logic       REG_WE,
   output logic [1:0] REG_SEL,
   output logic [4:0] REG_DATA,
   output logic       CTRL_RESET,
   output logic [2:0] SHIFT_CNT
);

   localparam int             HCW      = $clog2(M2_MIN_HIGH + 1);
   localparam logic [HCW-1:0] HMIN     = HCW'(M2_MIN_HIGH);
   localparam logic [2:0]     LAST_BIT = 3'(SHIFT_LEN - 1);

   logic [6:0] pins_s;
   logic [6:0] synced_s;
   logic       m2_s;
   bus_cap_t   bus_s;

   assign pins_s = {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7};

   mmc1_sync #(
      .WIDTH  (7),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (CLK),
      .d_i   (pins_s),
      .q_o   (synced_s)
   );

   assign m2_s  = synced_s[6];
   assign bus_s = bus_cap_t'(synced_s[5:0]);

   cyc_state_e     state_q;
   logic [HCW-1:0] hcnt_q;
   logic           m2_prev_q;
   bus_cap_t       cap_q;
   logic           last_was_write_q;
   logic [3:0]     sr_q;
   logic [2:0]     cnt_q;
   logic           reg_we_q;
   logic           ctrl_reset_q;
   logic [1:0]     reg_sel_q;
   logic [4:0]     reg_data_q;

   // m2_prev_q resets high so an M2 already high at RST release is not a rise.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q          <= CYC_IDLE;
         hcnt_q           <= '0;
         m2_prev_q        <= 1'b1;
         cap_q            <= '0;
         last_was_write_q <= 1'b0;
         sr_q             <= 4'b0000;
         cnt_q            <= 3'd0;
         reg_we_q         <= 1'b0;
         ctrl_reset_q     <= 1'b0;
         reg_sel_q        <= 2'b00;
         reg_data_q       <= 5'b00000;
      end else begin
         m2_prev_q    <= m2_s;
         reg_we_q     <= 1'b0;
         ctrl_reset_q <= 1'b0;
         if (m2_s) begin
            cap_q <= bus_s;
         end
         case (state_q)
            CYC_IDLE: begin
               if (m2_s && !m2_prev_q) begin
                  state_q <= CYC_HIGH;
                  hcnt_q  <= HCW'(1);
               end
            end
            CYC_HIGH: begin
               if (m2_s) begin
                  if (hcnt_q < HMIN) begin
                     hcnt_q <= hcnt_q + HCW'(1);
                  end
               end else begin
                  state_q <= CYC_IDLE;
                  if (hcnt_q >= HMIN) begin
                     if (cap_q.romsel_n || cap_q.rw_n) begin
                        last_was_write_q <= 1'b0;
                     end else if (!last_was_write_q) begin
                        last_was_write_q <= 1'b1;
                        if (cap_q.d7) begin
                           sr_q         <= 4'b0000;
                           cnt_q        <= 3'd0;
                           ctrl_reset_q <= 1'b1;
                        end else if (cnt_q < LAST_BIT) begin
                           sr_q  <= {cap_q.d0, sr_q[3:1]};
                           cnt_q <= cnt_q + 3'd1;
                        end else begin
                           reg_data_q <= {cap_q.d0, sr_q};
                           reg_sel_q  <= cap_q.sel;
                           reg_we_q   <= 1'b1;
                           sr_q       <= 4'b0000;
                           cnt_q      <= 3'd0;
                        end
                     end
                  end
               end
            end
            default: state_q <= CYC_IDLE;
         endcase
      end
   end

   assign REG_WE     = reg_we_q;
   assign CTRL_RESET = ctrl_reset_q;
   assign REG_SEL    = reg_sel_q;
   assign REG_DATA   = reg_data_q;
   assign SHIFT_CNT  = cnt_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Directed bench for mmc1_serial_loader with a queue-based protocol model.
module tb_mmc1_serial_loader;

   localparam int SYNC = 2;
   localparam int MINH = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       m2, romsel_n, rw_n, a14, a13, d0, d7;
   logic       reg_we, ctrl_reset;
   logic [1:0] reg_sel;
   logic [4:0] reg_data;
   logic [2:0] shift_cnt;

   mmc1_serial_loader #(.SYNC_STAGES(SYNC), .M2_MIN_HIGH(MINH)) dut (
      .CLK         (clk),
      .RST         (rst),
      .CPU_M2      (m2),
      .nCPU_ROMSEL (romsel_n),
      .nCPU_RW     (rw_n),
      .CPU_A14     (a14),
      .CPU_A13     (a13),
      .CPU_D0      (d0),
      .CPU_D7      (d7),
      .REG_WE      (reg_we),
      .REG_SEL     (reg_sel),
      .REG_DATA    (reg_data),
      .CTRL_RESET  (ctrl_reset),
      .SHIFT_CNT   (shift_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int we_seen = 0;
   int cr_seen = 0;

   // Protocol model: accepted data bits are kept in arrival order.
   bit       bits[$];
   bit       flag_m;
   int       exp_we, exp_cr, exp_sel, exp_data, exp_cnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bits.delete();
      flag_m   = 1'b0;
      exp_we   = 0;
      exp_cr   = 0;
      exp_sel  = 0;
      exp_data = 0;
      exp_cnt  = 0;
   endtask

   task automatic model_cycle(input int hi, input bit rs, input bit rw,
                              input bit s14, input bit s13, input bit b0, input bit b7);
      int v;
      if (hi < MINH) return;
      if (rs || rw) begin
         flag_m = 1'b0;
         return;
      end
      if (flag_m) return;
      flag_m = 1'b1;
      if (b7) begin
         bits.delete();
         exp_cr = 1;
      end else begin
         bits.push_back(b0);
         if (bits.size() == 5) begin
            v = 0;
            foreach (bits[i]) v += int'(bits[i]) << i;
            exp_data = v;
            exp_sel  = s14 * 2 + s13;
            exp_we   = 1;
            bits.delete();
         end
      end
      exp_cnt = bits.size();
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("REG_WE", int'(reg_we), exp_we);
         chk("CTRL_RESET", int'(ctrl_reset), exp_cr);
         chk("REG_SEL", int'(reg_sel), exp_sel);
         chk("REG_DATA", int'(reg_data), exp_data);
         chk("SHIFT_CNT", int'(shift_cnt), exp_cnt);
         if (reg_we) we_seen++;
         if (ctrl_reset) cr_seen++;
      end
   end

   // One CPU bus cycle with M2 high for 'hi' clocks; model updates SYNC+1 edges after the fall.
   task automatic bus_cycle(input int hi, input bit rs, input bit rw,
                            input bit s14, input bit s13, input bit b0, input bit b7);
      @(posedge clk); #2;
      romsel_n = rs; rw_n = rw; a14 = s14; a13 = s13; d0 = b0; d7 = b7;
      m2 = 1'b1;
      repeat (hi) @(posedge clk);
      #2;
      m2 = 1'b0; romsel_n = 1'b1; rw_n = 1'b1; d0 = ~b0; a14 = ~s14;
      repeat (SYNC + 1) @(posedge clk);
      #1;
      model_cycle(hi, rs, rw, s14, s13, b0, b7);
      @(posedge clk); #1;
      exp_we = 0;
      exp_cr = 0;
      repeat (2) @(posedge clk);
   endtask

   task automatic wr(input bit s14, input bit s13, input bit b0, input bit b7);
      bus_cycle(4, 1'b0, 1'b0, s14, s13, b0, b7);
   endtask

   task automatic rd();
      bus_cycle(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      bit [4:0] pat;
      rst = 1'b1; m2 = 1'b0; romsel_n = 1'b1; rw_n = 1'b1;
      a14 = 1'b0; a13 = 1'b0; d0 = 1'b0; d7 = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_we", int'(reg_we), 0);
      chk("reset_sel", int'(reg_sel), 0);
      chk("reset_data", int'(reg_data), 0);
      chk("reset_cnt", int'(shift_cnt), 0);

      // Five writes to $E000, D0 = 1,0,1,1,0, reads between.
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         wr(1'b1, 1'b1, pat[i], 1'b0);
         rd();
      end
      chk("t1_data", int'(reg_data), 13);
      chk("t1_sel", int'(reg_sel), 3);
      chk("t1_cnt", int'(shift_cnt), 0);
      chk("t1_we_count", we_seen, 1);

      // Two bits, then D7 reset.
      wr(1'b1, 1'b1, 1'b1, 1'b0); rd();
      wr(1'b1, 1'b1, 1'b1, 1'b0); rd();
      wr(1'b1, 1'b1, 1'b0, 1'b1); rd();
      chk("t2_cr_count", cr_seen, 1);
      chk("t2_we_count", we_seen, 1);
      chk("t2_cnt", int'(shift_cnt), 0);

      // Five writes to $A000, D0 = 1,1,0,0,1.
      pat = 5'b10011;
      for (int i = 0; i < 5; i++) begin
         wr(1'b0, 1'b1, pat[i], 1'b0);
         rd();
      end
      chk("t2_sel", int'(reg_sel), 1);
      chk("t2_data", int'(reg_data), 19);
      chk("t2_we_count2", we_seen, 2);

      // RMW pair of resets, then write, write, read, write.
      wr(1'b1, 1'b1, 1'b0, 1'b1);
      wr(1'b1, 1'b1, 1'b0, 1'b1);
      rd();
      chk("t3_cr_count", cr_seen, 2);
      wr(1'b1, 1'b1, 1'b1, 1'b0);
      wr(1'b1, 1'b1, 1'b0, 1'b0);
      rd();
      wr(1'b1, 1'b1, 1'b1, 1'b0);
      rd();
      chk("t3_cnt", int'(shift_cnt), 2);

      // Short M2 pulses are ignored and leave the filter flag untouched.
      bus_cycle(MINH - 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t4_glitch_cnt", int'(shift_cnt), 2);
      wr(1'b1, 1'b1, 1'b0, 1'b0);
      bus_cycle(MINH - 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wr(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t4_cnt", int'(shift_cnt), 3);

      // Reset mid-load, then a clean load to $C000.
      pulse_reset();
      chk("t5_rst_cnt", int'(shift_cnt), 0);
      chk("t5_rst_data", int'(reg_data), 0);
      pat = 5'b01110;
      for (int i = 0; i < 5; i++) begin
         wr(1'b1, 1'b0, pat[i], 1'b0);
         rd();
      end
      chk("t5_data", int'(reg_data), 14);
      chk("t5_sel", int'(reg_sel), 2);
      chk("t5_we_count", we_seen, 3);

      // M2 high across RST release: that cycle must be ignored.
      @(posedge clk); #2;
      romsel_n = 1'b0; rw_n = 1'b0; d7 = 1'b1; d0 = 1'b1; m2 = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      #2 m2 = 1'b0; romsel_n = 1'b1; rw_n = 1'b1;
      repeat (6) @(posedge clk);
      chk("t6_cr_count", cr_seen, 2);

      // Writes outside ROM space are ignored.
      bus_cycle(4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      bus_cycle(4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t7_cnt", int'(shift_cnt), 0);
      chk("t7_cr_count", cr_seen, 2);
      chk("t7_we_count", we_seen, 3);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
